// File: rtl/gqed_tracker.sv
// gqed_tracker: arms a check on one transaction index, counts the inputs fed
// to and outputs taken from a DUT, captures the DUT result for that index and
// the isolated-reference result, and compares the two. A stalled output
// stream past the liveness bound also ends the check in FAIL.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no check armed
// RUN      | feeding inputs, waiting for both the DUT and the reference result
// WAIT_REF | DUT result captured, waiting for the reference result
// WAIT_DUT | reference result captured, waiting for the DUT result
// CHECK    | both captured, compare on the next enabled cycle
// PASS     | captures matched (done held until start or rst)
// FAIL     | captures differed or liveness bound hit (done held)

module gqed_tracker #(
  parameter int  DATA_W  = 16,
  parameter int  SEQ_LEN = 16,
  parameter int  TMO_CYC = 64,
  localparam int IDX_W   = $clog2(SEQ_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              start,
  input  logic [IDX_W-1:0]  sel_idx,
  input  logic              in_vld,
  input  logic              in_rdy,
  input  logic              out_vld,
  input  logic              out_rdy,
  input  logic [DATA_W-1:0] dut_data,
  input  logic              ref_vld,
  input  logic [DATA_W-1:0] ref_data,
  output logic              seq_sel,
  output logic [IDX_W-1:0]  seq_ptr,
  output logic [IDX_W:0]    in_cnt,
  output logic [IDX_W:0]    out_cnt,
  output logic [DATA_W-1:0] cap_dut,
  output logic [DATA_W-1:0] cap_ref,
  output logic [2:0]        state,
  output logic              done,
  output logic              mismatch,
  output logic              timeout
);

  localparam int               TMR_W    = $clog2(TMO_CYC + 1);
  localparam logic [IDX_W:0]   SEQ_MAX  = (IDX_W + 1)'(SEQ_LEN);
  // The timer is loaded with TMO_CYC-1 and fails on the enabled cycle that
  // finds it already at zero, i.e. the TMO_CYC-th stalled cycle.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    WAIT_REF = 3'd2,
    WAIT_DUT = 3'd3,
    CHECK    = 3'd4,
    PASS     = 3'd5,
    FAIL     = 3'd6
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [TMR_W-1:0] tmr_q;

  logic             in_acc;
  logic             out_acc;
  logic             st_run;
  logic             st_watch;
  logic             st_ref_open;
  logic [IDX_W:0]   idx_ext;
  logic [IDX_W:0]   idx_p1;
  logic             in_step;
  logic             out_step;
  logic             dut_hit;
  logic             ref_hit;
  logic             tmr_tc;
  logic             dut_have;
  logic             ref_have;

  assign in_acc      = clk_en && in_vld && in_rdy;
  assign out_acc     = clk_en && out_vld && out_rdy;

  // Output stream is still watched until the DUT result is captured; the
  // reference is still awaited until its result is captured.
  assign st_run      = (state_q == RUN);
  assign st_watch    = (state_q == RUN) || (state_q == WAIT_DUT);
  assign st_ref_open = (state_q == RUN) || (state_q == WAIT_REF);

  // Widened by one bit so idx_q+1 cannot wrap for the top index.
  assign idx_ext     = {1'b0, idx_q};
  assign idx_p1      = idx_ext + 1'b1;

  assign in_step     = st_run   && in_acc  && (in_cnt  <= idx_p1) && (in_cnt  < SEQ_MAX);
  assign out_step    = st_watch && out_acc && (out_cnt <= idx_p1) && (out_cnt < SEQ_MAX);
  assign dut_hit     = st_watch && out_acc && (out_cnt == idx_ext);
  assign ref_hit     = st_ref_open && clk_en && ref_vld;
  assign tmr_tc      = st_watch && !out_acc && (tmr_q == '0);

  assign dut_have    = dut_hit || (state_q == WAIT_REF);
  assign ref_have    = ref_hit || (state_q == WAIT_DUT);

  assign seq_sel     = (in_cnt <= idx_ext);
  assign seq_ptr     = in_cnt[IDX_W-1:0];
  assign state       = state_q;

  // Tracker FSM, counters, captures and sticky flags; nothing moves without clk_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tmr_q    <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      cap_dut  <= '0;
      cap_ref  <= '0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      timeout  <= 1'b0;
    end else if (clk_en) begin
      case (state_q)
        IDLE, PASS, FAIL: begin
          if (start) begin
            state_q  <= RUN;
            idx_q    <= sel_idx;
            tmr_q    <= TMR_LOAD;
            in_cnt   <= '0;
            out_cnt  <= '0;
            cap_dut  <= '0;
            cap_ref  <= '0;
            done     <= 1'b0;
            mismatch <= 1'b0;
            timeout  <= 1'b0;
          end
        end

        RUN, WAIT_REF, WAIT_DUT: begin
          if (in_step)  in_cnt  <= in_cnt + 1'b1;
          if (out_step) out_cnt <= out_cnt + 1'b1;
          if (dut_hit)  cap_dut <= dut_data;
          if (ref_hit)  cap_ref <= ref_data;

          if (st_watch) begin
            if (out_acc)      tmr_q <= TMR_LOAD;
            else if (!tmr_tc) tmr_q <= tmr_q - 1'b1;
          end

          // Liveness failure outranks a reference arriving in the same cycle.
          if (tmr_tc) begin
            state_q  <= FAIL;
            done     <= 1'b1;
            timeout  <= 1'b1;
            mismatch <= 1'b0;
          end else if (dut_have && ref_have) begin
            state_q <= CHECK;
          end else if (dut_have) begin
            state_q <= WAIT_REF;
          end else if (ref_have) begin
            state_q <= WAIT_DUT;
          end
        end

        CHECK: begin
          done <= 1'b1;
          if (cap_dut == cap_ref) begin
            state_q <= PASS;
          end else begin
            state_q  <= FAIL;
            mismatch <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gqed_tracker.sv
// Testbench for gqed_tracker: directed scenarios with constant expectations,
// then randomized traffic checked every cycle against a transaction-level model.

module tb_gqed_tracker;

  localparam int DATA_W  = 16;
  localparam int SEQ_LEN = 16;
  localparam int TMO     = 64;
  localparam int IDX_W   = 4;

  logic              clk = 1'b0;
  logic              rst, clk_en, start, in_vld, in_rdy, out_vld, out_rdy, ref_vld;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] dut_data, ref_data;
  logic              seq_sel;
  logic [IDX_W-1:0]  seq_ptr;
  logic [IDX_W:0]    in_cnt, out_cnt;
  logic [DATA_W-1:0] cap_dut, cap_ref;
  logic [2:0]        state;
  logic              done, mismatch, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: progress expressed as "what has been collected so far".
  bit          m_active, m_gd, m_gr, m_chk, m_mis, m_tmo;
  int          m_res;   // 0 undecided, 1 pass, 2 fail
  int          m_idx, m_in, m_out, m_stall;
  logic [15:0] m_cd, m_cr;

  gqed_tracker #(.DATA_W(DATA_W), .SEQ_LEN(SEQ_LEN), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .sel_idx(sel_idx),
    .in_vld(in_vld), .in_rdy(in_rdy), .out_vld(out_vld), .out_rdy(out_rdy),
    .dut_data(dut_data), .ref_vld(ref_vld), .ref_data(ref_data),
    .seq_sel(seq_sel), .seq_ptr(seq_ptr), .in_cnt(in_cnt), .out_cnt(out_cnt),
    .cap_dut(cap_dut), .cap_ref(cap_ref), .state(state), .done(done),
    .mismatch(mismatch), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    m_active = 0; m_gd = 0; m_gr = 0; m_chk = 0; m_mis = 0; m_tmo = 0;
    m_res = 0; m_idx = 0; m_in = 0; m_out = 0; m_stall = 0; m_cd = '0; m_cr = '0;
  endfunction

  function automatic void model_step();
    bit oacc, waiting, newd, newr;
    if (rst) begin model_clear(); return; end
    if (!clk_en) return;
    if ((!m_active || m_res != 0) && start) begin
      model_clear();
      m_active = 1;
      m_idx    = int'(sel_idx);
      return;
    end
    if (!m_active || m_res != 0) return;
    if (m_chk) begin
      m_chk = 0;
      if (m_cd == m_cr) m_res = 1;
      else begin m_res = 2; m_mis = 1; end
      return;
    end
    oacc    = out_vld && out_rdy;
    waiting = !m_gd;
    newd    = waiting && oacc && (m_out == m_idx);
    newr    = !m_gr && ref_vld;
    if (!m_gd && !m_gr && in_vld && in_rdy && m_in <= m_idx + 1 && m_in < SEQ_LEN) m_in++;
    if (waiting && oacc && m_out <= m_idx + 1 && m_out < SEQ_LEN) m_out++;
    if (newd) m_cd = dut_data;
    if (newr) m_cr = ref_data;
    if (waiting) begin
      if (oacc) m_stall = 0;
      else begin
        m_stall++;
        if (m_stall >= TMO) begin m_res = 2; m_tmo = 1; m_mis = 0; return; end
      end
    end
    m_gd = m_gd | newd;
    m_gr = m_gr | newr;
    if (m_gd && m_gr) m_chk = 1;
  endfunction

  function automatic int exp_state();
    if (!m_active)  return 0;
    if (m_res == 1) return 5;
    if (m_res == 2) return 6;
    if (m_chk)      return 4;
    if (m_gd)       return 2;
    if (m_gr)       return 3;
    return 1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; clk_en = 1; start = 0; sel_idx = '0; in_vld = 0; in_rdy = 0;
    out_vld = 0; out_rdy = 0; ref_vld = 0; dut_data = '0; ref_data = '0;
  endtask

  task automatic arm(input int idx);
    idle_inputs();
    start = 1; sel_idx = IDX_W'(idx);
    cyc();
    start = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if ({in_cnt, out_cnt} !== 10'd0) begin n_bad++; $display("FAIL reset_cnt: got in=%0d out=%0d want 0/0", in_cnt, out_cnt); end
    n_cmp++; if ({cap_dut, cap_ref} !== 32'd0) begin n_bad++; $display("FAIL reset_cap: got %h/%h want 0/0", cap_dut, cap_ref); end
    n_cmp++; if ({done, mismatch, timeout} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {done, mismatch, timeout}); end
    n_cmp++; if ({seq_sel, seq_ptr} !== 5'b1_0000) begin n_bad++; $display("FAIL reset_seq: got sel=%b ptr=%0d want 1/0", seq_sel, seq_ptr); end
  endtask

  task automatic test_identity();
    arm(3);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL id_arm: got %0d want 1", state); end
    for (int k = 0; k < 4; k++) begin
      in_vld = 1; in_rdy = 1; out_vld = 1; out_rdy = 1;
      dut_data = 16'(8'h11 * (k + 1));
      ref_vld = (k == 3); ref_data = 16'h0044;
      cyc();
    end
    idle_inputs();
    n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL id_check_state: got %0d want 4", state); end
    n_cmp++; if (cap_dut !== 16'h0044 || cap_ref !== 16'h0044) begin n_bad++; $display("FAIL id_caps: got %h/%h want 0044/0044", cap_dut, cap_ref); end
    cyc();
    n_cmp++; if ({state, done, mismatch, timeout} !== {3'd5, 3'b100}) begin n_bad++; $display("FAIL id_pass: got st=%0d flags=%b want 5/100", state, {done, mismatch, timeout}); end
    n_cmp++; if (in_cnt !== 5'd4 || out_cnt !== 5'd4 || seq_sel !== 1'b0) begin n_bad++; $display("FAIL id_counts: got in=%0d out=%0d sel=%b want 4/4/0", in_cnt, out_cnt, seq_sel); end
  endtask

  task automatic test_corruption();
    arm(0);
    out_vld = 1; out_rdy = 1; dut_data = 16'hBEEF;
    cyc();
    idle_inputs();
    n_cmp++; if (state !== 3'd2 || cap_dut !== 16'hBEEF) begin n_bad++; $display("FAIL cor_wait_ref: got st=%0d cap=%h want 2/beef", state, cap_dut); end
    ref_vld = 1; ref_data = 16'hBEEE;
    cyc();
    idle_inputs();
    n_cmp++; if (state !== 3'd4 || mismatch !== 1'b0) begin n_bad++; $display("FAIL cor_check: got st=%0d mis=%b want 4/0", state, mismatch); end
    cyc();
    n_cmp++; if ({state, done, mismatch, timeout} !== {3'd6, 3'b110}) begin n_bad++; $display("FAIL cor_fail: got st=%0d flags=%b want 6/110", state, {done, mismatch, timeout}); end
  endtask

  task automatic test_backpressure();
    arm(1);
    out_vld = 1; out_rdy = 0; dut_data = 16'h000A;
    for (int k = 0; k < 10; k++) cyc();
    n_cmp++; if (out_cnt !== 5'd0 || state !== 3'd1 || timeout !== 1'b0) begin n_bad++; $display("FAIL bp_frozen: got out=%0d st=%0d tmo=%b want 0/1/0", out_cnt, state, timeout); end
    out_rdy = 1;
    cyc();
    dut_data = 16'h000B; ref_vld = 1; ref_data = 16'h000B;
    cyc();
    idle_inputs();
    cyc();
    n_cmp++; if (state !== 3'd5 || cap_dut !== 16'h000B || timeout !== 1'b0) begin n_bad++; $display("FAIL bp_pass: got st=%0d cap=%h tmo=%b want 5/000b/0", state, cap_dut, timeout); end
  endtask

  task automatic test_liveness();
    arm(2);
    for (int k = 0; k < TMO - 1; k++) cyc();
    n_cmp++; if (state !== 3'd1 || timeout !== 1'b0) begin n_bad++; $display("FAIL live_early: got st=%0d tmo=%b want 1/0", state, timeout); end
    cyc();
    n_cmp++; if ({state, done, mismatch, timeout} !== {3'd6, 3'b101}) begin n_bad++; $display("FAIL live_fail: got st=%0d flags=%b want 6/101", state, {done, mismatch, timeout}); end
  endtask

  task automatic test_ordering_gating();
    arm(2);
    ref_vld = 1; ref_data = 16'h5A5A;
    cyc();
    idle_inputs();
    n_cmp++; if (state !== 3'd3 || cap_ref !== 16'h5A5A) begin n_bad++; $display("FAIL ord_wait_dut: got st=%0d ref=%h want 3/5a5a", state, cap_ref); end
    out_vld = 1; out_rdy = 1; dut_data = 16'h0001;
    cyc();
    clk_en = 0; start = 1; ref_vld = 1; ref_data = 16'h0000; in_vld = 1; in_rdy = 1;
    out_vld = 1; out_rdy = 1; dut_data = 16'h5A5A;
    for (int k = 0; k < 4; k++) cyc();
    n_cmp++; if ({state, in_cnt, out_cnt} !== {3'd3, 5'd0, 5'd1}) begin n_bad++; $display("FAIL gate_cnt: got st=%0d in=%0d out=%0d want 3/0/1", state, in_cnt, out_cnt); end
    n_cmp++; if ({cap_dut, cap_ref, done} !== {16'h0000, 16'h5A5A, 1'b0}) begin n_bad++; $display("FAIL gate_cap: got %h/%h done=%b want 0000/5a5a/0", cap_dut, cap_ref, done); end
    idle_inputs();
    start = 1; sel_idx = '0; out_vld = 1; out_rdy = 1; dut_data = 16'h0002;
    cyc();
    start = 0; dut_data = 16'h5A5A;
    cyc();
    idle_inputs();
    n_cmp++; if (state !== 3'd4 || cap_dut !== 16'h5A5A) begin n_bad++; $display("FAIL ord_check: got st=%0d cap=%h want 4/5a5a", state, cap_dut); end
    cyc();
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL ord_pass: got %0d want 5", state); end
  endtask

  task automatic test_reset_midrun();
    arm(1);
    out_vld = 1; out_rdy = 1; dut_data = 16'h0010;
    cyc();
    dut_data = 16'h0020;
    cyc();
    idle_inputs();
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL rm_wait_ref: got %0d want 2", state); end
    rst = 1; start = 1; clk_en = 0;
    cyc();
    idle_inputs();
    n_cmp++; if ({state, in_cnt, out_cnt, cap_dut, cap_ref, done, mismatch, timeout} !== '0) begin n_bad++; $display("FAIL rm_cleared: got st=%0d out=%0d cap=%h flags=%b want all 0", state, out_cnt, cap_dut, {done, mismatch, timeout}); end
    arm(0);
    n_cmp++; if (state !== 3'd1 || out_cnt !== 5'd0) begin n_bad++; $display("FAIL rm_rearm: got st=%0d out=%0d want 1/0", state, out_cnt); end
    out_vld = 1; out_rdy = 1; dut_data = 16'h0077; ref_vld = 1; ref_data = 16'h0077;
    cyc();
    idle_inputs();
    cyc();
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL rm_pass: got %0d want 5", state); end
  endtask

  task automatic test_random();
    logic [52:0] act, exp;
    int ovld_pct;
    ovld_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) ovld_pct = (ovld_pct == 50) ? 2 : 50;
      rst      = ($urandom_range(0, 299) == 0);
      clk_en   = ($urandom_range(0, 99) < 85);
      start    = ($urandom_range(0, 19) == 0);
      sel_idx  = ($urandom_range(0, 3) == 0) ? IDX_W'($urandom_range(0, 15)) : IDX_W'($urandom_range(0, 4));
      in_vld   = ($urandom_range(0, 99) < 60);
      in_rdy   = ($urandom_range(0, 99) < 70);
      out_vld  = ($urandom_range(0, 99) < ovld_pct);
      out_rdy  = ($urandom_range(0, 99) < 70);
      ref_vld  = ($urandom_range(0, 9) == 0);
      dut_data = 16'($urandom_range(0, 2));
      ref_data = 16'($urandom_range(0, 2));
      cyc();
      act = {state, in_cnt, out_cnt, cap_dut, cap_ref, done, mismatch, timeout, seq_sel, seq_ptr};
      exp = {3'(exp_state()), 5'(m_in), 5'(m_out), m_cd, m_cr, (m_res != 0), m_mis, m_tmo,
             (m_in <= m_idx), 4'(m_in)};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL rand_cycle %0d: got %h want %h (st cnt cnt cap cap d m t sel ptr)", c, act, exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_clear();
    idle_inputs();
    test_reset();
    test_identity();
    test_corruption();
    test_backpressure();
    test_liveness();
    test_ordering_gating();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
